// File: rtl/sd_pkg.sv
// Shared definitions for the sigma-delta receive path.
//   SD_WIN_LOG2_DEF : default log2 window length
//   sd_out_w()      : output width needed to hold a full-scale window count
//   sd_state_t      : decimator control state
package sd_pkg;

  localparam int SD_WIN_LOG2_DEF = 8;

  typedef enum logic {SD_IDLE, SD_RUN} sd_state_t;

  // A window of 2^win_log2 samples can count up to 2^win_log2 ones,
  // which needs one bit more than the sample counter.
  function automatic int sd_out_w(input int win_log2);
    return win_log2 + 1;
  endfunction

endpackage

// File: rtl/sd_decim_if.sv
// Result port of the sigma-delta decimator.
//   data_out   : completed window count
//   data_valid : data_out holds an unconsumed result
//   data_ready : consumer accepts data_out
// Handshake: a result transfers on every rising clk edge where
// data_valid and data_ready are both high. The producer keeps data_out
// stable while data_valid is high unless a newer result overwrites it;
// data_ready may be held high permanently.
// Modports: master = decimator side, slave = consumer side.
import sd_pkg::*;

interface sd_decim_if #(
  parameter int OUT_W = sd_out_w(SD_WIN_LOG2_DEF)
);
  logic [OUT_W-1:0] data_out;
  logic             data_valid;
  logic             data_ready;

  modport master (output data_out, output data_valid, input data_ready);
  modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/sd_sync2.sv
// Two-flop synchronizer for a single asynchronous bit (comparator outputs).
//   clk   : destination clock
//   rst_n : synchronous active-low reset, clears both flops
//   d     : asynchronous input
//   q     : synchronized output, two clk edges behind d
module sd_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/sd_decim.sv
// Sigma-delta decimator: counts ones in the synchronized modulator
// bitstream over windows of 2^WIN_LOG2 sample strobes and presents each
// completed window count on a valid/ready port.
//   clk, rst_n : system clock, synchronous active-low reset
//   enable     : run enable; low returns to IDLE and clears the path
//   smp_en     : single-cycle sample strobe
//   bit_in     : asynchronous modulator bitstream
//   out_if     : result port (data_out / data_valid / data_ready)
//   overrun    : sticky, a result was overwritten before being consumed
//   state      : current control state, for observation
// Build option: define SD_DECIM_SIGNED_EN to output the two's complement
// value count - 2^(WIN_LOG2-1) instead of the raw count.
module sd_decim
  import sd_pkg::*;
#(
  parameter int WIN_LOG2 = SD_WIN_LOG2_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         enable,
  input  logic         smp_en,
  input  logic         bit_in,
  sd_decim_if.master   out_if,
  output logic         overrun,
  output sd_state_t    state
);

  localparam int OUT_W = sd_out_w(WIN_LOG2);
  localparam logic [WIN_LOG2-1:0] CNT_LAST = '1;

  logic                bs;
  logic [WIN_LOG2-1:0] sample_cnt;
  logic [OUT_W-1:0]    ones_acc;
  logic [OUT_W-1:0]    win_sum;
  logic [OUT_W-1:0]    win_result;
  logic [OUT_W-1:0]    data_out_q;
  logic                data_valid_q;

  sd_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (bit_in),
    .q     (bs)
  );

  // Count including the current sample; at window end this is the total.
  assign win_sum = ones_acc + {{(OUT_W-1){1'b0}}, bs};

`ifdef SD_DECIM_SIGNED_EN
  localparam logic [OUT_W-1:0] HALF = OUT_W'(1) << (WIN_LOG2 - 1);
  // Mid-scale offset removed in the same cycle as the load.
  assign win_result = win_sum - HALF;
`else
  assign win_result = win_sum;
`endif

  assign out_if.data_out   = data_out_q;
  assign out_if.data_valid = data_valid_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= SD_IDLE;
      sample_cnt   <= '0;
      ones_acc     <= '0;
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      case (state)
        SD_IDLE: begin
          // data_out deliberately keeps the last result.
          sample_cnt   <= '0;
          ones_acc     <= '0;
          data_valid_q <= 1'b0;
          overrun      <= 1'b0;
          if (enable) state <= SD_RUN;
        end
        SD_RUN: begin
          if (!enable) begin
            // Partial window is discarded.
            state        <= SD_IDLE;
            sample_cnt   <= '0;
            ones_acc     <= '0;
            data_valid_q <= 1'b0;
            overrun      <= 1'b0;
          end else begin
            if (data_valid_q && out_if.data_ready) data_valid_q <= 1'b0;
            if (smp_en) begin
              sample_cnt <= sample_cnt + 1'b1;
              if (sample_cnt == CNT_LAST) begin
                // Window end overrides the accept clear: a new result is
                // always valid. Overrun only if the old one was not taken.
                data_out_q   <= win_result;
                ones_acc     <= '0;
                data_valid_q <= 1'b1;
                if (data_valid_q && !out_if.data_ready) overrun <= 1'b1;
              end else begin
                ones_acc <= win_sum;
              end
            end
          end
        end
        default: state <= SD_IDLE;
      endcase
    end
  end

endmodule

// File: doc/sd_decim.md
Name: sd_decim

Overview:
- Receive end of the sigma-delta path: takes the 1-bit modulator bitstream and turns it back into a multi-bit sample.
- Counts ones over a fixed window of 2^WIN_LOG2 samples.
- Samples are paced by one strobe from the clock divider's enable bus (e.g. clk/4).
- Each completed window is presented on a valid/ready output port toward the readout/UI logic.

Parameters:
- WIN_LOG2, 8, log2 of window length in samples (legal 2..12).
- OUT_W, WIN_LOG2+1, output width; holds full-scale count 2^WIN_LOG2. Derived, not overridable.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk
- enable  in  1  run enable; low = idle and cleared
- smp_en  in  1  single-cycle sample strobe from the divider enable bus
- bit_in  in  1  modulator bitstream (comparator output, asynchronous to clk)
- data_out  out  OUT_W  last completed window count
- data_valid  out  1  data_out holds an unconsumed result
- data_ready  in  1  consumer accepts data_out when high with data_valid
- overrun  out  1  sticky: a result was overwritten before being consumed

Behaviour:
- Reset (rst_n=0 at posedge): clears data_out, data_valid, overrun, the internal counters and both synchronizer flops; state=IDLE.
- bit_in passes through a 2-flop synchronizer. The counted bit is bs = second flop.
- State IDLE:
  - Counters held at 0; data_valid and overrun forced 0; data_out retains its value.
  - enable=1 moves to RUN on the next edge.
- State RUN:
  - On every cycle with smp_en=1: sample_cnt (WIN_LOG2 bits) increments with wrap, and ones_acc (OUT_W bits) += bs.
  - Window end: smp_en=1 and sample_cnt = 2^WIN_LOG2-1.
    - data_out <= ones_acc + bs.
    - ones_acc <= 0 (the last sample belongs to the closing window); sample_cnt wraps to 0.
    - data_valid <= 1.
  - smp_en=0 cycles change nothing.
- Latency: data_valid rises 1 clk after the window's last strobe. Bitstream to count adds 2 clk of synchronizer delay.
- Handshake:
  - data_valid & data_ready clears data_valid on that edge.
  - data_out is stable while data_valid=1 until accepted or overwritten.
- Simultaneous window end and accept: the new result is loaded, data_valid stays 1, overrun unchanged.
- Window end while data_valid=1 and data_ready=0:
  - Newest result overwrites data_out.
  - data_valid stays 1; overrun <= 1 (sticky).
- overrun clears only by reset or by returning to IDLE.
- enable dropped mid-window: next edge enters IDLE; the partial window is discarded, data_valid and overrun cleared.
- Re-enable: the first window starts with the first smp_en strobe after entering RUN.
- smp_en stuck high is legal: one sample per clk.
- Range: all-ones window gives 2^WIN_LOG2 (MSB set, others 0); all-zeros gives 0. No saturation is needed.

Optional Feature:
- Macro SD_DECIM_SIGNED_EN.
- Defined: data_out is two's complement count - 2^(WIN_LOG2-1).
  - Range -2^(WIN_LOG2-1) .. +2^(WIN_LOG2-1) in OUT_W bits.
  - 50% duty cycle gives 0.
  - Subtraction is registered together with the window-end load, so latency is unchanged.
- Undefined: unsigned count as above.

Decomposition:
- Shared package sd_pkg:
  - SD_WIN_LOG2_DEF = 8.
  - Output width function, defined as WIN_LOG2+1.
  - State typedef {SD_IDLE, SD_RUN}.
- One natural sub-module: sd_sync2, the 2-flop bit synchronizer with synchronous reset. It is reusable for other comparator inputs.
- The counter, accumulator and handshake stay in sd_decim.

Test Plan (WIN_LOG2=4, smp_en every 4th clk):
- Reset while running, then release → data_out=0, data_valid=0, overrun=0; first result only after 16 strobes.
- bit_in constant 1, data_ready=1 → data_out=16 (unsigned) / +8 (signed), one valid pulse per 16 strobes.
- bit_in alternating 1/0 per strobe → data_out=8 (unsigned) / 0 (signed); bit_in=0 → data_out=0 / -8.
- data_ready=0 across two window ends with bit_in=1 then 0 → data_out=0, data_valid=1, overrun=1. Then enable=0 → data_valid=0, overrun=0.
- data_ready pulsed on the exact window-end edge → new value loaded, data_valid stays 1, no overrun.
- enable dropped after 7 strobes, raised again, then 16 strobes of 1 → data_out=16 (partial window discarded).
